// File: rtl/hci_mem_bank_adapter.sv
// hci_mem_bank_adapter
//   Terminal per-bank stage of the TCDM interconnect. It accepts one request at
//   a time from a memory-side master port, drives a single-port synchronous
//   SRAM macro (1-cycle read latency), optionally holds the bank busy for
//   WAIT_CYCLES extra cycles, and returns exactly one response per access.
//
// Ports
//   clk_i, rst_i (async, active high), clear_i (sync soft clear)
//   req_i/gnt_o/add_i/wen_i/be_i/data_i/id_i/user_i : request channel
//   r_valid_o/r_data_o/r_id_o/r_user_o              : response channel
//   sram_ce_o/sram_we_o/sram_addr_o/sram_wdata_o/sram_bwe_o/sram_rdata_i : macro
module hci_mem_bank_adapter #(
    parameter int AW          = 10,
    parameter int DW          = 32,
    parameter int BW          = 8,
    parameter int IW          = 8,
    parameter int UW          = 1,
    parameter int WAIT_CYCLES = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               req_i,
    output logic               gnt_o,
    input  logic [AW-1:0]      add_i,
    input  logic               wen_i,
    input  logic [DW/BW-1:0]   be_i,
    input  logic [DW-1:0]      data_i,
    input  logic [IW-1:0]      id_i,
    input  logic [UW-1:0]      user_i,
    output logic               r_valid_o,
    output logic [DW-1:0]      r_data_o,
    output logic [IW-1:0]      r_id_o,
    output logic [UW-1:0]      r_user_o,
    output logic               sram_ce_o,
    output logic               sram_we_o,
    output logic [AW-1:0]      sram_addr_o,
    output logic [DW-1:0]      sram_wdata_o,
    output logic [DW-1:0]      sram_bwe_o,
    input  logic [DW-1:0]      sram_rdata_i
);

    localparam int NB = DW / BW;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            pending;
    logic            resp_fire;
    logic            accept;

    // Capture registers follow the access in flight; response registers feed
    // the response channel, so an accept in a response cycle cannot disturb
    // the outgoing ID/user.
    logic [IW-1:0]   cap_id,   resp_id;
    logic [UW-1:0]   cap_user, resp_user;
    logic            cap_wen,  resp_wen;
    logic [DW-1:0]   hold;

    // Reset and clear both block new accepts combinationally.
    assign gnt_o  = req_i & (state == IDLE) & ~clear_i & ~rst_i;
    assign accept = gnt_o;

    assign sram_ce_o    = accept;
    assign sram_we_o    = accept & ~wen_i;
    assign sram_addr_o  = accept ? add_i  : '0;
    assign sram_wdata_o = accept ? data_i : '0;

    always_comb begin
        sram_bwe_o = '0;
        for (int k = 0; k < NB; k++)
            sram_bwe_o[k*BW +: BW] = {BW{be_i[k] & accept & ~wen_i}};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            pending   <= 1'b0;
            cap_id    <= '0;
            cap_user  <= '0;
            cap_wen   <= 1'b0;
            resp_id   <= '0;
            resp_user <= '0;
            resp_wen  <= 1'b0;
            hold      <= '0;
        end else if (clear_i) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            pending <= 1'b0;
            if (accept) begin
                cap_id   <= id_i;
                cap_user <= user_i;
                cap_wen  <= wen_i;
                if (WAIT_CYCLES == 0) begin
                    // No wait states: response is due next cycle.
                    resp_id   <= id_i;
                    resp_user <= user_i;
                    resp_wen  <= wen_i;
                    pending   <= 1'b1;
                end else begin
                    state <= BUSY;
                    cnt   <= CW'(WAIT_CYCLES);
                end
            end
            if (state == BUSY) begin
                // First busy cycle is the one where the macro's read data is valid.
                if (cnt == CW'(WAIT_CYCLES))
                    hold <= sram_rdata_i;
                if (cnt == CW'(1)) begin
                    state     <= IDLE;
                    cnt       <= '0;
                    pending   <= 1'b1;
                    resp_id   <= cap_id;
                    resp_user <= cap_user;
                    resp_wen  <= cap_wen;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

    // A clear in the response cycle suppresses that response.
    assign resp_fire = pending & ~clear_i;
    assign r_valid_o = resp_fire;
    assign r_id_o    = resp_fire ? resp_id   : '0;
    assign r_user_o  = resp_fire ? resp_user : '0;
    assign r_data_o  = (resp_fire & resp_wen) ?
                       ((WAIT_CYCLES == 0) ? sram_rdata_i : hold) : '0;

endmodule

// File: tb/tb_hci_mem_bank_adapter.sv
// Directed bench: three adapters (WAIT_CYCLES 0, 2, 3) share one stimulus bus,
// each with its own behavioural SRAM preloaded with 0xC0DE0000 | address.
module tb_hci_mem_bank_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clear, req, wen;
    logic [9:0]  add;
    logic [3:0]  be;
    logic [31:0] data;
    logic [7:0]  id;
    logic [0:0]  user;

    logic [2:0]        gnt, r_valid, sram_ce, sram_we;
    logic [2:0][31:0]  r_data, sram_wdata, sram_bwe, sram_rdata;
    logic [2:0][7:0]   r_id;
    logic [2:0][0:0]   r_user;
    logic [2:0][9:0]   sram_addr;

    int n_chk = 0;
    int n_err = 0;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int W = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        logic [31:0] mem [1024];
        logic [31:0] rdq = '0;

        initial for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);

        always @(posedge clk) begin
            if (sram_ce[g]) begin
                if (sram_we[g])
                    mem[sram_addr[g]] <= (mem[sram_addr[g]] & ~sram_bwe[g]) |
                                         (sram_wdata[g] & sram_bwe[g]);
                else
                    rdq <= mem[sram_addr[g]];
            end
        end
        assign sram_rdata[g] = rdq;

        hci_mem_bank_adapter #(.WAIT_CYCLES(W)) dut (
            .clk_i(clk), .rst_i(rst), .clear_i(clear),
            .req_i(req), .gnt_o(gnt[g]), .add_i(add), .wen_i(wen),
            .be_i(be), .data_i(data), .id_i(id), .user_i(user),
            .r_valid_o(r_valid[g]), .r_data_o(r_data[g]),
            .r_id_o(r_id[g]), .r_user_o(r_user[g]),
            .sram_ce_o(sram_ce[g]), .sram_we_o(sram_we[g]),
            .sram_addr_o(sram_addr[g]), .sram_wdata_o(sram_wdata[g]),
            .sram_bwe_o(sram_bwe[g]), .sram_rdata_i(sram_rdata[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r, input logic w, input logic [9:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic [7:0] i);
        req = r; wen = w; add = a; data = d; be = b; id = i; user = i[0];
    endtask

    task automatic idle();
        clear = 1'b0;
        drv(1'b0, 1'b1, '0, '0, '0, '0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        req = 1'b1;
        @(negedge clk);
        // Reset state, with req held high
        check("rst_gnt0",   gnt[0],     0);
        check("rst_gnt2",   gnt[2],     0);
        check("rst_rv0",    r_valid[0], 0);
        check("rst_rdata0", r_data[0],  0);
        check("rst_rid2",   r_id[2],    0);
        check("rst_ce0",    sram_ce[0], 0);
        check("rst_bwe0",   sram_bwe[0], 0);
        check("rst_addr1",  sram_addr[1], 0);
        tick(); rst = 1'b0; idle();
        tick(); tick();

        // T1: W=0 write then read
        tick(); drv(1, 0, 10'h005, 32'hDEADBEEF, 4'hF, 8'd3);
        @(negedge clk);
        check("t1_gnt_wr",  gnt[0],       1);
        check("t1_we",      sram_we[0],   1);
        check("t1_addr",    sram_addr[0], 32'h5);
        check("t1_bwe",     sram_bwe[0],  32'hFFFFFFFF);
        tick(); drv(1, 1, 10'h005, 32'h0, 4'hF, 8'd7);
        @(negedge clk);
        check("t1_gnt_rd",  gnt[0],    1);
        check("t1_rv_wr",   r_valid[0], 1);
        check("t1_rid_wr",  r_id[0],   3);
        check("t1_rdat_wr", r_data[0], 0);
        check("t1_rd_bwe",  sram_bwe[0], 0);
        tick(); idle();
        @(negedge clk);
        check("t1_rv_rd",   r_valid[0], 1);
        check("t1_rid_rd",  r_id[0],   7);
        check("t1_ruser",   r_user[0], 1);
        check("t1_rdat_rd", r_data[0], 32'hDEADBEEF);
        tick();
        @(negedge clk);
        check("t1_rv_off",  r_valid[0], 0);
        check("t1_rid_off", r_id[0],   0);

        // T2: W=0 byte write into 0x11223344
        tick(); drv(1, 0, 10'h009, 32'h11223344, 4'hF, 8'd1);
        tick(); drv(1, 0, 10'h009, 32'h0000AB00, 4'b0010, 8'd2);
        @(negedge clk);
        check("t2_bwe",     sram_bwe[0],   32'h0000FF00);
        check("t2_wdata",   sram_wdata[0], 32'h0000AB00);
        tick(); drv(1, 1, 10'h009, 32'h0, 4'h0, 8'd4);
        tick(); idle();
        @(negedge clk);
        check("t2_rv",      r_valid[0], 1);
        check("t2_rdata",   r_data[0],  32'h1122AB44);
        repeat (5) tick();

        // T3: W=2 continuous reads at 1,2,3 (IDs 0x10..0x12)
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c < 9) drv(1, 1, 10'(1 + c/3), 32'h0, 4'h0, 8'(8'h10 + c/3));
            else idle();
            @(negedge clk);
            check($sformatf("t3_gnt_c%0d", c), gnt[1], (c < 9 && c % 3 == 0));
            check($sformatf("t3_rv_c%0d", c), r_valid[1], (c >= 3 && c % 3 == 0));
            if (c >= 3 && c % 3 == 0) begin
                check($sformatf("t3_rid_c%0d", c), r_id[1], 32'(8'h10 + c/3 - 1));
                check($sformatf("t3_rdat_c%0d", c), r_data[1], 32'hC0DE0000 | 32'(c/3));
            end
        end
        repeat (5) tick();

        // T4: clear one cycle after accept (W=2), and clear vs accept on W=0
        tick(); drv(1, 1, 10'h004, 32'h0, 4'h0, 8'h44);
        @(negedge clk);
        check("t4_gnt_acc", gnt[1], 1);
        tick(); drv(1, 1, 10'h004, 32'h0, 4'h0, 8'h45); clear = 1'b1;
        @(negedge clk);
        check("t4_gnt1_clr", gnt[1],     0);
        check("t4_gnt0_clr", gnt[0],     0);
        check("t4_ce0_clr",  sram_ce[0], 0);
        check("t4_rv0_clr",  r_valid[0], 0);
        tick(); clear = 1'b0; drv(1, 1, 10'h006, 32'h0, 4'h0, 8'h66);
        @(negedge clk);
        check("t4_gnt_next", gnt[1],    1);
        check("t4_rv_a2",    r_valid[1], 0);
        tick(); idle();
        @(negedge clk);
        check("t4_rv_a3",    r_valid[1], 0);
        tick();
        @(negedge clk);
        check("t4_rv_a4",    r_valid[1], 0);
        tick();
        @(negedge clk);
        check("t4_rv_a5",    r_valid[1], 1);
        check("t4_rid_a5",   r_id[1],   32'h66);
        check("t4_rdat_a5",  r_data[1], 32'hC0DE0006);
        repeat (5) tick();

        // T5: reset mid-BUSY (W=3)
        tick(); drv(1, 1, 10'h000, 32'h0, 4'h0, 8'h5A);
        @(negedge clk);
        check("t5_gnt_acc", gnt[2], 1);
        tick(); idle();
        #1 rst = 1'b1; drv(1, 1, 10'h003, 32'h0, 4'h0, 8'h77);
        @(negedge clk);
        check("t5_rst_gnt", gnt[2],     0);
        check("t5_rst_ce",  sram_ce[2], 0);
        check("t5_rst_rv",  r_valid[2], 0);
        check("t5_rst_rid", r_id[2],    0);
        tick(); rst = 1'b0; idle();
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            check($sformatf("t5_norsp_%0d", c), r_valid[2], 0);
        end
        tick(); drv(1, 1, 10'h000, 32'h0, 4'h0, 8'h21);
        @(negedge clk);
        check("t5_gnt_new", gnt[2], 1);
        tick(); idle();
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            @(negedge clk);
            check($sformatf("t5_rv_d%0d", c), r_valid[2], (c == 4));
        end
        check("t5_rid",  r_id[2],   32'h21);
        check("t5_rdat", r_data[2], 32'hC0DE0000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
